// File: rtl/dsbpm_turn_marker_gen_if.sv
// -----------------------------------------------------------------------------
// dsbpm_turn_marker_gen_if
//
// Bundles the sample strobe, EVR sync controls, requested geometry and the
// marker/status outputs of the DSBPM turn-marker generator.
//
//   master : drives sampleValid, evrSync, syncEnable and the requested
//            geometry; observes markers, turnIndex, synced, syncErrCount.
//   slave  : the generator side (the mirror image of master).
//
// The width parameters must match those of the generator instance that
// binds to the slave modport.
// -----------------------------------------------------------------------------
interface dsbpm_turn_marker_gen_if #(
    parameter int SPT_WIDTH = 8,
    parameter int TPT_WIDTH = 6,
    parameter int FA_WIDTH  = 8,
    parameter int SA_WIDTH  = 12,
    parameter int ERR_WIDTH = 16
);
    // Sample strobe and sync controls
    logic                  sampleValid;
    logic                  evrSync;
    logic                  syncEnable;

    // Requested geometry (only becomes active at an SA end or honoured sync)
    logic [SPT_WIDTH-1:0]  samplesPerTurn;
    logic [TPT_WIDTH-1:0]  turnsPerPt;
    logic [FA_WIDTH-1:0]   faDecimate;
    logic [SA_WIDTH-1:0]   saDecimate;

    // Markers and status
    logic                  turnMarker;
    logic                  ptMarker;
    logic                  faMarker;
    logic                  saMarker;
    logic [TPT_WIDTH-1:0]  turnIndex;
    logic                  synced;
    logic [ERR_WIDTH-1:0]  syncErrCount;

    modport master (
        output sampleValid, evrSync, syncEnable,
        output samplesPerTurn, turnsPerPt, faDecimate, saDecimate,
        input  turnMarker, ptMarker, faMarker, saMarker,
        input  turnIndex, synced, syncErrCount
    );

    modport slave (
        input  sampleValid, evrSync, syncEnable,
        input  samplesPerTurn, turnsPerPt, faDecimate, saDecimate,
        output turnMarker, ptMarker, faMarker, saMarker,
        output turnIndex, synced, syncErrCount
    );
endinterface

// File: rtl/dsbpm_turn_marker_gen.sv
// -----------------------------------------------------------------------------
// dsbpm_turn_marker_gen
//
// Timing generator for the DSBPM signal chain. Counts ADC sample strobes and
// emits single-cycle markers on the last sample of each turn, pilot-tone
// cycle, FA period and SA period. An EVR sync event realigns the counters so
// that the next valid sample is SA sample 0; syncs that arrive off-phase
// (while already synced) are counted in a saturating error counter.
//
// Ports:
//   clk  : ADC-domain clock
//   rst  : asynchronous, active-high reset
//   bus  : slave side of dsbpm_turn_marker_gen_if
//          in  sampleValid, evrSync, syncEnable,
//              samplesPerTurn, turnsPerPt, faDecimate, saDecimate
//          out turnMarker, ptMarker, faMarker, saMarker,
//              turnIndex, synced, syncErrCount
//
// All outputs are registered; markers appear one clock after the cycle that
// presented the final sample of their period.
// -----------------------------------------------------------------------------
module dsbpm_turn_marker_gen #(
    parameter int SPT_WIDTH   = 8,
    parameter int TPT_WIDTH   = 6,
    parameter int FA_WIDTH    = 8,
    parameter int SA_WIDTH    = 12,
    parameter int ERR_WIDTH   = 16,
    parameter int DEFAULT_SPT = 77,
    parameter int DEFAULT_TPT = 19,
    parameter int DEFAULT_FA  = 76,
    parameter int DEFAULT_SA  = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    dsbpm_turn_marker_gen_if.slave  bus
);

    localparam logic [SPT_WIDTH-1:0] DEF_SPT = SPT_WIDTH'(DEFAULT_SPT);
    localparam logic [TPT_WIDTH-1:0] DEF_TPT = TPT_WIDTH'(DEFAULT_TPT);
    localparam logic [FA_WIDTH-1:0]  DEF_FA  = FA_WIDTH'(DEFAULT_FA);
    localparam logic [SA_WIDTH-1:0]  DEF_SA  = SA_WIDTH'(DEFAULT_SA);
    localparam logic [ERR_WIDTH-1:0] ERR_MAX = {ERR_WIDTH{1'b1}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    // Active geometry
    logic [SPT_WIDTH-1:0]  spt_reg;
    logic [TPT_WIDTH-1:0]  tpt_reg;
    logic [FA_WIDTH-1:0]   fa_reg;
    logic [SA_WIDTH-1:0]   sa_reg;

    // Position counters
    logic [SPT_WIDTH-1:0]  sample_cnt_reg, sample_cnt_next;
    logic [TPT_WIDTH-1:0]  turn_cnt_reg,   turn_cnt_next;
    logic [FA_WIDTH-1:0]   fa_cnt_reg,     fa_cnt_next;
    logic [SA_WIDTH-1:0]   sa_cnt_reg,     sa_cnt_next;

    // Registered outputs
    logic                  turn_marker_reg;
    logic                  pt_marker_reg;
    logic                  fa_marker_reg;
    logic                  sa_marker_reg;
    logic [TPT_WIDTH-1:0]  turn_index_reg;
    logic                  synced_reg;
    logic [ERR_WIDTH-1:0]  sync_err_cnt_reg;

    // -------------------------------------------------------------------------
    // Requested geometry, clamped to the smallest meaningful values
    // -------------------------------------------------------------------------
    logic [SPT_WIDTH-1:0]  spt_req;
    logic [TPT_WIDTH-1:0]  tpt_req;
    logic [FA_WIDTH-1:0]   fa_req;
    logic [SA_WIDTH-1:0]   sa_req;

    always_comb begin
        spt_req = (bus.samplesPerTurn < SPT_WIDTH'(2)) ? SPT_WIDTH'(2) : bus.samplesPerTurn;
        tpt_req = (bus.turnsPerPt == '0) ? TPT_WIDTH'(1) : bus.turnsPerPt;
        fa_req  = (bus.faDecimate == '0) ? FA_WIDTH'(1)  : bus.faDecimate;
        sa_req  = (bus.saDecimate == '0) ? SA_WIDTH'(1)  : bus.saDecimate;
    end

    // -------------------------------------------------------------------------
    // Period boundaries for the sample presented this cycle
    // -------------------------------------------------------------------------
    logic turn_end;
    logic pt_wrap;
    logic fa_wrap;
    logic sa_wrap;
    logic pt_end;
    logic fa_end;
    logic sa_end;

    always_comb begin
        turn_end = (sample_cnt_reg == spt_reg - SPT_WIDTH'(1));
        pt_wrap  = (turn_cnt_reg   == tpt_reg - TPT_WIDTH'(1));
        fa_wrap  = (fa_cnt_reg     == fa_reg  - FA_WIDTH'(1));
        sa_wrap  = (sa_cnt_reg     == sa_reg  - SA_WIDTH'(1));
        pt_end   = turn_end & pt_wrap;
        fa_end   = turn_end & fa_wrap;
        sa_end   = fa_end & sa_wrap;
    end

    // -------------------------------------------------------------------------
    // Counter update and sync phase evaluation
    // -------------------------------------------------------------------------
    logic honoured;     // evrSync that is acted upon this cycle
    logic post_zero;    // normal update would land on SA sample 0
    logic off_phase;    // honoured sync that disagrees with our phase
    logic emit;         // this cycle's sample produces markers
    logic cfg_load;     // load the requested geometry this cycle

    always_comb begin
        sample_cnt_next = sample_cnt_reg;
        turn_cnt_next   = turn_cnt_reg;
        fa_cnt_next     = fa_cnt_reg;
        sa_cnt_next     = sa_cnt_reg;

        if (bus.sampleValid) begin
            if (turn_end) begin
                sample_cnt_next = '0;
                turn_cnt_next   = pt_wrap ? '0 : turn_cnt_reg + TPT_WIDTH'(1);
                fa_cnt_next     = fa_wrap ? '0 : fa_cnt_reg + FA_WIDTH'(1);
                if (fa_wrap) begin
                    sa_cnt_next = sa_wrap ? '0 : sa_cnt_reg + SA_WIDTH'(1);
                end
            end else begin
                sample_cnt_next = sample_cnt_reg + SPT_WIDTH'(1);
            end
        end

        honoured  = bus.evrSync & bus.syncEnable;
        // In-phase means the normal update (including a concurrent sample)
        // already sits on SA sample 0, so nothing needs to be forced.
        post_zero = (sample_cnt_next == '0) && (turn_cnt_next == '0) &&
                    (fa_cnt_next == '0) && (sa_cnt_next == '0);
        off_phase = honoured & ~post_zero;

        if (off_phase) begin
            sample_cnt_next = '0;
            turn_cnt_next   = '0;
            fa_cnt_next     = '0;
            sa_cnt_next     = '0;
        end

        // An off-phase sync discards the concurrent sample's markers.
        emit     = bus.sampleValid & ~off_phase;
        // Geometry only changes where every counter restarts at zero, so the
        // counters can never sit beyond a newly shortened period.
        cfg_load = honoured | (emit & sa_end);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spt_reg          <= DEF_SPT;
            tpt_reg          <= DEF_TPT;
            fa_reg           <= DEF_FA;
            sa_reg           <= DEF_SA;
            sample_cnt_reg   <= '0;
            turn_cnt_reg     <= '0;
            fa_cnt_reg       <= '0;
            sa_cnt_reg       <= '0;
            turn_marker_reg  <= 1'b0;
            pt_marker_reg    <= 1'b0;
            fa_marker_reg    <= 1'b0;
            sa_marker_reg    <= 1'b0;
            turn_index_reg   <= '0;
            synced_reg       <= 1'b0;
            sync_err_cnt_reg <= '0;
        end else begin
            if (cfg_load) begin
                spt_reg <= spt_req;
                tpt_reg <= tpt_req;
                fa_reg  <= fa_req;
                sa_reg  <= sa_req;
            end

            sample_cnt_reg <= sample_cnt_next;
            turn_cnt_reg   <= turn_cnt_next;
            fa_cnt_reg     <= fa_cnt_next;
            sa_cnt_reg     <= sa_cnt_next;

            turn_marker_reg <= emit & turn_end;
            pt_marker_reg   <= emit & pt_end;
            fa_marker_reg   <= emit & fa_end;
            sa_marker_reg   <= emit & sa_end;
            turn_index_reg  <= turn_cnt_next;

            if (honoured) begin
                synced_reg <= 1'b1;
            end

            // The very first alignment after reset is not an error.
            if (off_phase && synced_reg && (sync_err_cnt_reg != ERR_MAX)) begin
                sync_err_cnt_reg <= sync_err_cnt_reg + ERR_WIDTH'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.turnMarker   = turn_marker_reg;
    assign bus.ptMarker     = pt_marker_reg;
    assign bus.faMarker     = fa_marker_reg;
    assign bus.saMarker     = sa_marker_reg;
    assign bus.turnIndex    = turn_index_reg;
    assign bus.synced       = synced_reg;
    assign bus.syncErrCount = sync_err_cnt_reg;

endmodule

// File: tb/tb_dsbpm_turn_marker_gen.sv
// -----------------------------------------------------------------------------
// tb_dsbpm_turn_marker_gen
//
// Directed bench for dsbpm_turn_marker_gen: default cadence, sync alignment,
// in-phase and off-phase syncs, disabled syncs, sample gaps, deferred
// geometry changes with clamping, asynchronous reset and error saturation.
// -----------------------------------------------------------------------------
module tb_dsbpm_turn_marker_gen;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    dsbpm_turn_marker_gen_if bus ();

    dsbpm_turn_marker_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // One clock: drive inputs at negedge, sample outputs 1 time unit after posedge.
    task automatic tick(input logic sv, input logic sy, input logic en);
        @(negedge clk);
        bus.sampleValid = sv;
        bus.evrSync     = sy;
        bus.syncEnable  = en;
        @(posedge clk);
        #1;
    endtask

    function automatic logic marker_sel(input int which);
        case (which)
            0:       return bus.turnMarker;
            1:       return bus.ptMarker;
            2:       return bus.faMarker;
            default: return bus.saMarker;
        endcase
    endfunction

    // Clock until the chosen marker fires; n = clocks taken, -1 on timeout.
    // With half set, samples are presented on every second clock (gap first).
    task automatic count_to(input int which, input bit half, input int budget, output int n);
        n = -1;
        for (int i = 0; i < budget; i++) begin
            tick(half ? logic'(i % 2 == 1) : 1'b1, 1'b0, 1'b0);
            if (marker_sel(which)) begin
                n = i + 1;
                return;
            end
        end
    endtask

    task automatic plain(input int k);
        for (int i = 0; i < k; i++) tick(1'b1, 1'b0, 1'b0);
    endtask

    localparam int TURN = 0, PT = 1, FA = 2, SA = 3;

    int n;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.sampleValid    = 1'b0;
        bus.evrSync        = 1'b0;
        bus.syncEnable     = 1'b0;
        bus.samplesPerTurn = 8'd77;
        bus.turnsPerPt     = 6'd19;
        bus.faDecimate     = 8'd76;
        bus.saDecimate     = 12'd1000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_turn",   int'(bus.turnMarker), 0);
        check_val("rst_sa",     int'(bus.saMarker), 0);
        check_val("rst_index",  int'(bus.turnIndex), 0);
        check_val("rst_synced", int'(bus.synced), 0);
        check_val("rst_err",    int'(bus.syncErrCount), 0);

        // 1. default cadence
        count_to(TURN, 0, 2000, n); check_val("t1_first_turn", n, 77);
        check_val("t1_index1", int'(bus.turnIndex), 1);
        count_to(TURN, 0, 2000, n); check_val("t1_second_turn", n, 77);
        check_val("t1_index2", int'(bus.turnIndex), 2);
        count_to(PT, 0, 2000, n);   check_val("t1_first_pt", n, 1463 - 154);
        check_val("t1_pt_index", int'(bus.turnIndex), 0);
        check_val("t1_pt_turn", int'(bus.turnMarker), 1);
        count_to(PT, 0, 2000, n);   check_val("t1_pt_period", n, 1463);

        // 2. small geometry + first sync (off phase, not yet synced)
        bus.samplesPerTurn = 8'd4;
        bus.turnsPerPt     = 6'd3;
        bus.faDecimate     = 8'd2;
        bus.saDecimate     = 12'd3;
        tick(1'b1, 1'b1, 1'b1);
        check_val("t2_synced", int'(bus.synced), 1);
        check_val("t2_err", int'(bus.syncErrCount), 0);
        count_to(TURN, 0, 100, n); check_val("t2_turn", n, 4);
        count_to(FA, 0, 100, n);   check_val("t2_fa", n, 4);
        check_val("t2_fa_index", int'(bus.turnIndex), 2);
        count_to(PT, 0, 100, n);   check_val("t2_pt", n, 4);
        count_to(SA, 0, 100, n);   check_val("t2_sa", n, 12);
        check_val("t2_sa_fa", int'(bus.faMarker), 1);
        check_val("t2_sa_pt", int'(bus.ptMarker), 1);
        check_val("t2_sa_index", int'(bus.turnIndex), 0);

        // 3. in-phase sync on the last sample of the next SA period
        plain(23);
        tick(1'b1, 1'b1, 1'b1);
        check_val("t3_sa", int'(bus.saMarker), 1);
        check_val("t3_err", int'(bus.syncErrCount), 0);
        count_to(TURN, 0, 100, n); check_val("t3_turn", n, 4);

        // 4. off-phase sync 5 samples after an SA boundary
        count_to(SA, 0, 100, n); check_val("t4_sa", n, 20);
        plain(5);
        tick(1'b0, 1'b1, 1'b1);
        check_val("t4_err1", int'(bus.syncErrCount), 1);
        count_to(TURN, 0, 100, n); check_val("t4_turn_after", n, 4);
        plain(3);
        tick(1'b1, 1'b1, 1'b1);   // would have been a turn+FA end
        check_val("t4_supp_turn", int'(bus.turnMarker), 0);
        check_val("t4_supp_fa", int'(bus.faMarker), 0);
        check_val("t4_err2", int'(bus.syncErrCount), 2);
        count_to(TURN, 0, 100, n); check_val("t4_turn_after2", n, 4);
        plain(2);
        tick(1'b1, 1'b1, 1'b0);   // disabled sync: plain sample
        check_val("t4_dis_err", int'(bus.syncErrCount), 2);
        check_val("t4_dis_synced", int'(bus.synced), 1);
        count_to(TURN, 0, 100, n); check_val("t4_dis_turn", n, 1);

        // 5. 50% duty, deferred geometry change, clamping
        count_to(TURN, 1, 100, n); check_val("t5_half1", n, 8);
        count_to(TURN, 1, 100, n); check_val("t5_half2", n, 8);
        bus.samplesPerTurn = 8'd6;
        count_to(TURN, 0, 100, n); check_val("t5_old_spt1", n, 4);
        count_to(TURN, 0, 100, n); check_val("t5_old_spt2", n, 4);
        check_val("t5_sa", int'(bus.saMarker), 1);
        count_to(TURN, 0, 100, n); check_val("t5_new_spt1", n, 6);
        count_to(TURN, 0, 100, n); check_val("t5_new_spt2", n, 6);
        bus.samplesPerTurn = 8'd0;
        bus.turnsPerPt     = 6'd0;
        count_to(SA, 0, 100, n);   check_val("t5_sa36", n, 24);
        count_to(TURN, 0, 100, n); check_val("t5_clamp_turn", n, 2);
        check_val("t5_clamp_pt", int'(bus.ptMarker), 1);
        count_to(TURN, 0, 100, n); check_val("t5_clamp_turn2", n, 2);
        check_val("t5_clamp_index", int'(bus.turnIndex), 0);

        // 6. asynchronous reset while outputs are active
        rst = 1'b1;
        #1;
        check_val("t6_rst_turn", int'(bus.turnMarker), 0);
        check_val("t6_rst_pt", int'(bus.ptMarker), 0);
        check_val("t6_rst_synced", int'(bus.synced), 0);
        check_val("t6_rst_err", int'(bus.syncErrCount), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.sampleValid = 1'b0;
        bus.evrSync     = 1'b0;
        count_to(TURN, 0, 2000, n); check_val("t6_default_turn", n, 77);
        check_val("t6_index", int'(bus.turnIndex), 1);

        // Saturation: a sync with every sample is always off phase
        tick(1'b1, 1'b1, 1'b1);
        check_val("t6_first_sync_err", int'(bus.syncErrCount), 0);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        check_val("t6_err_two", int'(bus.syncErrCount), 2);
        plain(0);
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
            bus.sampleValid = 1'b1;
            bus.evrSync     = 1'b1;
            bus.syncEnable  = 1'b1;
        end
        @(posedge clk);
        #1;
        check_val("t6_err_sat", int'(bus.syncErrCount), 65535);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
